// File: rtl/multicycle_controller.sv
// Control FSM for the shared-memory multicycle RV32 datapath (lw, sw, R-type, beq).
// Outputs are Moore from the state register, with mem_ready/zero gating a few strobes.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [1:0] alu_op,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_BEQ      = 4'd8,
    S_TRAP     = 4'd9
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Everything decodes under rst_n so all outputs drop the moment reset asserts.
  always_comb begin
    w_next     = S_FETCH;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    imm_src    = 2'b00;
    alu_op     = 2'b00;
    retire     = 1'b0;
    illegal    = 1'b0;
    state      = 4'd0;
    if (rst_n) begin
      state = r_state;
      case (r_state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
          w_next     = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_src   = 2'b10;
          case (op)
            OP_LW, OP_SW: w_next = S_MEMADR;
            OP_R:         w_next = S_EXECR;
            OP_BEQ:       w_next = S_BEQ;
            default:      w_next = S_TRAP;
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          imm_src   = (op == OP_SW) ? 2'b01 : 2'b00;
          if (op == OP_LW)      w_next = S_MEMREAD;
          else if (op == OP_SW) w_next = S_MEMWRITE;
          else                  w_next = S_TRAP;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          w_next  = mem_ready ? S_MEMWB : S_MEMREAD;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
          retire     = 1'b1;
          w_next     = S_FETCH;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
          retire    = mem_ready;
          w_next    = mem_ready ? S_FETCH : S_MEMWRITE;
        end
        S_EXECR: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b01;
          w_next    = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          w_next    = S_FETCH;
        end
        S_BEQ: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
          pc_write  = zero;
          retire    = 1'b1;
          w_next    = S_FETCH;
        end
        S_TRAP: begin
          illegal = 1'b1;
          w_next  = S_TRAP;
        end
        default: w_next = S_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected cycle traces built from the
// instruction's step list, wait counts and branch outcome, compared cycle by cycle.
module tb_multicycle_controller;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [1:0] alu_op;
    logic       retire;
    logic       illegal;
    logic [3:0] state;
  } ov_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_ILL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src, alu_op;
  logic       retire, illegal;
  logic [3:0] state;
  ov_t        obs;

  int errors = 0;
  int checks = 0;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_op(alu_op), .retire(retire), .illegal(illegal),
    .state(state)
  );

  assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                result_src, alu_src_a, alu_src_b, imm_src, alu_op, retire, illegal, state};

  always #5 clk = ~clk;

  task automatic chk(input ov_t e, input string tag);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
    end
  endtask

  // Drive mem_ready for one cycle, check mid-cycle, then advance past the next edge.
  task automatic step(input logic mr, input ov_t e, input string tag);
    mem_ready = mr;
    @(negedge clk);
    chk(e, tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk('0, "reset_async");
    @(posedge clk);
    #1;
    chk('0, "reset_hold");
    rst_n = 1'b1;
  endtask

  // fw/mw: wait cycles before mem_ready in FETCH and in the data access.
  task automatic run_instr(input int kind, input logic [6:0] ill_op, input int fw,
                           input int mw, input logic z, input bit abort);
    ov_t e;
    case (kind)
      K_LW:    op = 7'b0000011;
      K_SW:    op = 7'b0100011;
      K_R:     op = 7'b0110011;
      K_BEQ:   op = 7'b1100011;
      default: op = ill_op;
    endcase
    zero = z;

    e = '0; e.mem_req = 1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
    for (int i = 0; i < fw; i++) step(1'b0, e, "fetch_wait");
    e.ir_write = 1; e.pc_write = 1;
    step(1'b1, e, "fetch");

    e = '0; e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; e.imm_src = 2'b10; e.state = 4'd1;
    step(1'($urandom_range(0, 1)), e, "decode");

    if (kind == K_LW || kind == K_SW) begin
      e = '0; e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.state = 4'd2;
      e.imm_src = (kind == K_SW) ? 2'b01 : 2'b00;
      step(1'($urandom_range(0, 1)), e, "memadr");
    end

    case (kind)
      K_LW: begin
        e = '0; e.mem_req = 1; e.adr_src = 1; e.state = 4'd3;
        if (abort) begin
          mem_ready = 1'b0;
          #2;
          chk(e, "memread_pre_rst");
          rst_n = 1'b0;
          #1;
          chk('0, "rst_mid_memread");
          @(posedge clk);
          #1;
          chk('0, "rst_no_memwb");
          rst_n = 1'b1;
          return;
        end
        for (int i = 0; i < mw; i++) step(1'b0, e, "memread_wait");
        step(1'b1, e, "memread");
        e = '0; e.result_src = 2'b01; e.reg_write = 1; e.retire = 1; e.state = 4'd4;
        step(1'($urandom_range(0, 1)), e, "memwb");
      end
      K_SW: begin
        e = '0; e.mem_req = 1; e.mem_write = 1; e.adr_src = 1; e.state = 4'd5;
        for (int i = 0; i < mw; i++) step(1'b0, e, "memwrite_wait");
        e.retire = 1;
        step(1'b1, e, "memwrite");
      end
      K_R: begin
        e = '0; e.alu_src_a = 2'b10; e.alu_op = 2'b01; e.state = 4'd6;
        step(1'($urandom_range(0, 1)), e, "execr");
        e = '0; e.reg_write = 1; e.retire = 1; e.state = 4'd7;
        step(1'($urandom_range(0, 1)), e, "aluwb");
      end
      K_BEQ: begin
        e = '0; e.alu_src_a = 2'b10; e.alu_op = 2'b10; e.pc_write = z; e.retire = 1;
        e.state = 4'd8;
        step(1'($urandom_range(0, 1)), e, "beq");
      end
      default: begin
        e = '0; e.illegal = 1; e.state = 4'd9;
        for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), e, "trap");
        step(1'b1, e, "trap_ready_high");
        do_reset();
      end
    endcase
  endtask

  initial begin
    logic [6:0] rop;
    do_reset();
    run_instr(K_LW, '0, 0, 0, 1'b0, 1'b0);
    run_instr(K_SW, '0, 0, 2, 1'b0, 1'b0);
    run_instr(K_R, '0, 0, 0, 1'b1, 1'b0);
    run_instr(K_BEQ, '0, 0, 0, 1'b1, 1'b0);
    run_instr(K_BEQ, '0, 0, 0, 1'b0, 1'b0);
    do_reset();
    run_instr(K_R, '0, 3, 0, 1'b0, 1'b0);
    run_instr(K_ILL, 7'b1111111, 0, 0, 1'b0, 1'b0);
    run_instr(K_SW, '0, 1, 0, 1'b1, 1'b0);
    run_instr(K_LW, '0, 0, 0, 1'b0, 1'b1);
    run_instr(K_LW, '0, 0, 1, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int k;
      k = int'($urandom_range(0, 9));
      rop = 7'($urandom);
      // Flipping bit 2 of any legal opcode never lands on another legal one.
      if (rop == 7'b0000011 || rop == 7'b0100011 || rop == 7'b0110011 || rop == 7'b1100011)
        rop = rop ^ 7'b0000100;
      run_instr((k > 4) ? (k % 4) : k, rop, int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore/Mealy control FSM that sequences the shared multicycle RV32 datapath: one memory port for instruction and data, one ALU for PC increment, address, result and branch compare. It replaces single-cycle decoding for lw, sw, R-type and beq with a per-instruction state sequence. It drives every datapath enable and mux select, and stalls on a memory ready handshake.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  7  opcode from the instruction register; stable from DECODE until the return to FETCH
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory accepts or completes the current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  store request (valid only with mem_req)
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU-out register
- ir_write  out  1  load instruction register and old-PC register
- pc_write  out  1  load PC from the result bus
- reg_write  out  1  register-file write enable
- result_src  out  2  result select: 00 = ALU-out register, 01 = memory data register, 10 = ALU result
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4
- imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B
- alu_op  out  2  ALU operation: 00 = add, 01 = R-type (funct decode), 10 = branch subtract
- retire  out  1  one-cycle pulse on the final cycle of each instruction
- illegal  out  1  unsupported opcode trapped
- state  out  4  current state code, for debug

## Operation
- Opcodes: lw 0000011, sw 0100011, R-type 0110011, beq 1100011. Every other opcode is illegal.
- Default in every state: all enables 0 and all selects 00, except as listed below.
- FETCH (0):
  - Outputs: mem_req=1, alu_src_b=10, result_src=10.
  - If mem_ready=1: ir_write=1, pc_write=1, next state DECODE.
  - If mem_ready=0: stay in FETCH.
- DECODE (1):
  - Outputs: alu_src_a=01, alu_src_b=01, imm_src=10 (branch target latched into ALU-out).
  - Next state: lw or sw → MEMADR; R-type → EXECR; beq → BEQ; otherwise → TRAP.
- MEMADR (2):
  - Outputs: alu_src_a=10, alu_src_b=01, imm_src=00 for lw, 01 for sw.
  - Next state: lw → MEMREAD; sw → MEMWRITE.
- MEMREAD (3):
  - Outputs: mem_req=1, adr_src=1.
  - Next state: MEMWB on mem_ready, else stay.
- MEMWB (4):
  - Outputs: result_src=01, reg_write=1, retire=1.
  - Next state: FETCH.
- MEMWRITE (5):
  - Outputs: mem_req=1, mem_write=1, adr_src=1.
  - On mem_ready: retire=1, next state FETCH. Otherwise stay.
- EXECR (6):
  - Outputs: alu_src_a=10, alu_op=01.
  - Next state: ALUWB.
- ALUWB (7):
  - Outputs: reg_write=1, retire=1.
  - Next state: FETCH.
- BEQ (8):
  - Outputs: alu_src_a=10, alu_op=10, result_src=00, pc_write=zero, retire=1.
  - Next state: FETCH.
- TRAP (9):
  - Outputs: illegal=1, all enables 0.
  - Stays in TRAP until reset.
- Codes 10–15 are unreachable. If entered, the FSM goes to TRAP on the next edge.

## Timing
- State register updates on the clk rising edge.
- rst_n low forces state to FETCH immediately (asynchronous).
  - While rst_n is low, every output is 0 (including mem_req) and state=0.
  - Reset mid-instruction abandons the instruction: no reg_write, pc_write or mem_write is issued after assertion.
- After rst_n deasserts, the first rising edge sees FETCH outputs with mem_req=1.
- Output decode:
  - Outputs decode from state (Moore).
  - Exceptions: ir_write, pc_write and retire in FETCH/MEMWRITE are gated by mem_ready; pc_write in BEQ is gated by zero.
- mem_ready is ignored in non-memory states. It may stay high continuously.
- Memory handshake: mem_req, mem_write and adr_src stay stable while waiting for mem_ready.
- Latency with zero wait states: lw 5 cycles, sw 4, R-type 4, beq 3.
- Each wait cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- retire pulses exactly once per completed instruction and never in TRAP.

## Test plan
- lw, mem_ready tied 1 → state sequence 0,1,2,3,4,0.
  - imm_src=00 in MEMADR.
  - reg_write=1 and result_src=01 only in cycle 5.
  - retire pulses once.
- sw with mem_ready low for 2 cycles in MEMWRITE → mem_req=1, mem_write=1, adr_src=1 held for 3 cycles.
  - retire and the FETCH transition occur on the cycle with mem_ready=1.
  - reg_write never asserts.
- R-type then beq, zero=1 → R-type: alu_op=01 in EXECR, reg_write in ALUWB.
  - beq: pc_write=1 in BEQ, alu_op=10, result_src=00.
  - Repeat beq with zero=0 → pc_write=0, retire=1.
- FETCH stall: mem_ready=0 for 3 cycles after reset → state stays 0, ir_write=0, pc_write=0.
  - Advance to DECODE one edge after mem_ready=1.
- op=1111111 in DECODE → TRAP (9), illegal=1 permanently.
  - All enables 0 regardless of mem_ready.
  - rst_n pulse returns to FETCH with illegal=0.
- rst_n asserted asynchronously mid-MEMREAD (between edges) → outputs 0 immediately.
  - state=0, no MEMWB write.
  - After release, a clean FETCH begins.
